ct_spsram_512x7_ctrl: RTL and testbench

//  Initiator-side controller for one 512x7 single-port SRAM macro. Accepts read/write

---
 rtl/ct_spsram_512x7_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ct_spsram_512x7_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_spsram_512x7_ctrl.sv
// ct_spsram_512x7_ctrl: valid/ready initiator for one 512x7 single-port SRAM macro.
// Optional post-reset array clear to INIT_VAL is enabled by defining CT_SPSRAM_INIT_CLR_EN.
module ct_spsram_512x7_ctrl #(
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    DATA_WIDTH = 7,
    parameter int                    RSP_DEPTH  = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(RSP_DEPTH - 1);

    logic                  run;
    logic                  init_wr;
    logic [ADDR_WIDTH-1:0] init_a;

    logic                  acc;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  credit;
    logic                  pop;
    logic                  push;
    logic                  rd_inflight;
    logic [CW-1:0]         fifo_cnt;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];

`ifdef CT_SPSRAM_INIT_CLR_EN
    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_A = '1;

    state_t                state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  init_q;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state    <= S_INIT;
            init_cnt <= '0;
            init_q   <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LAST_A) begin
                        state  <= S_RUN;
                        init_q <= 1'b1;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

    assign run       = (state == S_RUN);
    assign init_wr   = (state == S_INIT);
    assign init_a    = init_cnt;
    assign init_done = init_q;
`else
    // Holds off requests for the first cycle after reset release.
    logic live;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    assign run       = live;
    assign init_wr   = 1'b0;
    assign init_a    = '0;
    assign init_done = 1'b1;
`endif

    // Reads need a FIFO slot reserved for every read still in the macro.
    assign pop     = rsp_vld & rsp_rdy;
    assign push    = rd_inflight;
    assign credit  = ({1'b0, fifo_cnt} + (CW + 1)'(rd_inflight))
                   < (DEPTH_W + (CW + 1)'(pop));
    assign req_rdy = run & (req_wr | credit);
    assign acc     = req_vld & req_rdy;
    assign rd_acc  = acc & ~req_wr;
    assign wr_acc  = acc & req_wr & (|req_wmask);

    assign rsp_vld  = (fifo_cnt != '0);
    assign rsp_data = rsp_vld ? mem[rd_ptr] : '0;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_inflight <= 1'b0;
            fifo_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            rd_inflight <= rd_acc;
            if (push) begin
                mem[wr_ptr] <= sram_q;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (init_wr) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = init_a;
            sram_d    = INIT_VAL;
        end else if (wr_acc) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = ~req_wmask;
            sram_a    = req_addr;
            sram_d    = req_wdata;
        end else if (rd_acc) begin
            sram_cen  = 1'b0;
            sram_a    = req_addr;
        end
    end

endmodule

// File: tb/tb_ct_spsram_512x7_ctrl.sv
// Bench for ct_spsram_512x7_ctrl: SRAM macro model, reference model with
// per-cycle compare, and directed scenarios. Works with or without CT_SPSRAM_INIT_CLR_EN.
`timescale 1ns/1ps
module tb_ct_spsram_512x7_ctrl;

    localparam int         DEPTH = 2;
    localparam logic [6:0] IV    = 7'h00;
`ifdef CT_SPSRAM_INIT_CLR_EN
    localparam int RUN_K = 512;
`else
    localparam int RUN_K = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_vld = 1'b0;
    logic       req_rdy;
    logic       req_wr = 1'b0;
    logic [8:0] req_addr = '0;
    logic [6:0] req_wdata = '0;
    logic [6:0] req_wmask = '0;
    logic       rsp_vld;
    logic       rsp_rdy = 1'b1;
    logic [6:0] rsp_data;
    logic       init_done;
    logic       sram_cen;
    logic       sram_gwen;
    logic [6:0] sram_wen;
    logic [8:0] sram_a;
    logic [6:0] sram_d;
    logic [6:0] sram_q;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ct_spsram_512x7_ctrl #(
        .ADDR_WIDTH(9), .DATA_WIDTH(7), .RSP_DEPTH(DEPTH), .INIT_VAL(IV)
    ) dut (
        .forever_cpuclk(clk), .cpurst_b(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
        .init_done(init_done),
        .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
        .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
    );

    // Behavioural macro: Q valid the cycle after a read access.
    logic [6:0] sm [512];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) begin
                for (int i = 0; i < 7; i++)
                    if (!sram_wen[i]) sm[sram_a][i] <= sram_d[i];
            end else begin
                sram_q <= sm[sram_a];
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: array contents plus queue of expected responses.
    typedef struct {
        logic [6:0] d;
        bit         known;
        int         due;
    } rsp_t;

    rsp_t       q[$];
    logic [6:0] mm [512];
    bit         kn [512];
    int         k;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) k <= 0;
        else        k <= k + 1;

    always @(negedge clk) begin
        bit         ev, er, acc, popm;
        logic       e_cen, e_gwen;
        logic [6:0] e_wen, e_d, a_d;
        logic [8:0] e_a;
        if (!rst_n) begin
            q.delete();
            check("rst_req_rdy", req_rdy, 0);
            check("rst_rsp_vld", rsp_vld, 0);
            check("rst_rsp_data", rsp_data, 0);
`ifdef CT_SPSRAM_INIT_CLR_EN
            check("rst_init_done", init_done, 0);
`else
            check("rst_init_done", init_done, 1);
`endif
        end else begin
            ev = (q.size() > 0) && (q[0].due <= k);
            check("rsp_vld", rsp_vld, ev);
            if (ev && q[0].known) check("rsp_data", rsp_data, q[0].d);
            popm = ev && rsp_rdy;
            er = (k >= RUN_K) && (req_wr || (q.size() - int'(popm)) < DEPTH);
            check("req_rdy", req_rdy, er);
`ifdef CT_SPSRAM_INIT_CLR_EN
            check("init_done", init_done, k >= 512);
`else
            check("init_done", init_done, 1);
`endif
            acc = req_vld && er;
            e_cen = 1; e_gwen = 1; e_wen = '1; e_a = '0; e_d = '0; a_d = sram_d;
            if (popm) void'(q.pop_front());
`ifdef CT_SPSRAM_INIT_CLR_EN
            if (k < 512) begin
                e_cen = 0; e_gwen = 0; e_wen = '0; e_a = k[8:0]; e_d = IV;
                mm[k] = IV; kn[k] = 1;
            end else
`endif
            if (acc && req_wr && req_wmask != 0) begin
                e_cen = 0; e_gwen = 0; e_wen = ~req_wmask; e_a = req_addr; e_d = req_wdata;
                mm[req_addr] = (mm[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
                kn[req_addr] = kn[req_addr] | (req_wmask == 7'h7F);
            end else if (acc && !req_wr) begin
                e_cen = 0; e_a = req_addr; a_d = '0;
                q.push_back('{d: mm[req_addr], known: kn[req_addr], due: k + 2});
            end
            check("sram_pins", {sram_cen, sram_gwen, sram_wen, sram_a, a_d},
                  {e_cen, e_gwen, e_wen, e_a, e_d});
        end
    end

    task automatic send(input bit wr, input logic [8:0] a, input logic [6:0] wd,
                        input logic [6:0] wm, output int n, output logic cen,
                        output logic [6:0] wen);
        bit got;
        req_vld = 1; req_wr = wr; req_addr = a; req_wdata = wd; req_wmask = wm;
        n = 0; got = 0; cen = 1; wen = '1;
        while (!got && n < 100) begin
            @(negedge clk);
            got = req_rdy; cen = sram_cen; wen = sram_wen;
            @(posedge clk); #1;
            n++;
        end
        req_vld = 0;
        check("send_accepted", got, 1);
    endtask

    task automatic wr1(input logic [8:0] a, input logic [6:0] wd, input logic [6:0] wm);
        int n; logic c; logic [6:0] w;
        send(1, a, wd, wm, n, c, w);
    endtask

    task automatic read1(input logic [8:0] a, input logic [6:0] exp, input string nm);
        int n, lat; logic c; logic [6:0] w, d; bit seen;
        send(0, a, '0, '0, n, c, w);
        lat = 0; seen = 0; d = 'x;
        while (!seen && lat < 20) begin
            @(negedge clk); lat++;
            if (rsp_vld) begin seen = 1; d = rsp_data; end
        end
        @(posedge clk); #1;
        check({nm, "_latency"}, lat, 2);
        check(nm, d, exp);
    endtask

    task automatic wait_init();
`ifdef CT_SPSRAM_INIT_CLR_EN
        int n; logic [8:0] a0; logic c0;
        n = 0; a0 = 'x; c0 = 'x;
        while (n < 700) begin
            @(negedge clk); n++;
            if (n == 1) begin a0 = sram_a; c0 = sram_cen; end
            if (init_done) break;
        end
        check("init_first_a", a0, 0);
        check("init_first_cen", c0, 0);
        check("init_done_cycle", n, 513);
`else
        @(negedge clk);
        check("rdy_first_cycle", req_rdy, 0);
        @(negedge clk);
        check("rdy_second_cycle", req_rdy, 1);
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, acc_cnt, stale;
        logic c;
        logic [6:0] w;

        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        wait_init();
`ifdef CT_SPSRAM_INIT_CLR_EN
        read1(9'h1FF, IV, "init_val_1ff");
`endif

        // Full write, then low-nibble clear.
        send(1, 9'h055, 7'h7F, 7'h7F, n, c, w);
        check("wen_full", w, 7'h00);
        send(1, 9'h055, 7'h00, 7'h0F, n, c, w);
        check("wen_partial", w, 7'h70);
        read1(9'h055, 7'h70, "masked_write");

        // Zero-mask write is dropped.
        send(1, 9'h055, 7'h0A, 7'h00, n, c, w);
        check("zero_mask_cen", c, 1);
        read1(9'h055, 7'h70, "zero_mask_keep");

        // Read right after write to the same entry.
        wr1(9'h100, 7'h2A, 7'h7F);
        read1(9'h100, 7'h2A, "raw_same_addr");

        // Sixteen back-to-back reads.
        for (int i = 0; i < 16; i++) wr1(9'h040 + 9'(i), 7'(i * 5 + 3), 7'h7F);
        for (int i = 0; i < 16; i++) begin
            send(0, 9'h040 + 9'(i), '0, '0, n, c, w);
            check("b2b_one_cycle", n, 1);
        end
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: only DEPTH reads get credit.
        rsp_rdy = 0; req_vld = 1; req_wr = 0; acc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            req_addr = 9'h040 + 9'(acc_cnt);
            @(negedge clk);
            if (req_rdy) acc_cnt++;
            @(posedge clk); #1;
        end
        req_addr = 9'h040 + 9'(acc_cnt);
        #1 check("bp_rdy_low", req_rdy, 0);
        req_vld = 0;
        check("bp_accepts", acc_cnt, DEPTH);
        send(1, 9'h030, 7'h33, 7'h7F, n, c, w);
        check("bp_write_ok", n, 1);
        rsp_rdy = 1;
        repeat (4) @(posedge clk);
        #1;
        read1(9'h030, 7'h33, "bp_resume");

        // Reset with a read in flight and a queued response.
        rsp_rdy = 0;
        send(0, 9'h041, '0, '0, n, c, w);
        send(0, 9'h042, '0, '0, n, c, w);
        rst_n = 0;
        #1 check("async_rst_vld", rsp_vld, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        rsp_rdy = 1;
        wait_init();
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_vld) stale++;
        end
        check("no_stale_rsp", stale, 0);
        @(posedge clk); #1;
        wr1(9'h077, 7'h5C, 7'h7F);
        read1(9'h077, 7'h5C, "post_reset_rw");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
